// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-product vending controller with programmable price/stock, bounded credit and greedy change.
//   CLK, RST (async, active high); Manage/Confirm/ProdSel/PriceIn/StockIn program products in PROG;
//   Coin50..Coin1000 insert credit; Start/Done/TakeOut/Return are customer and brewer events;
//   Return50..Return1000 one-cycle coin-eject pulses; Making/Coffee brew status; Sum credit; SoldOut per product.
module vend_ctrl_multi #(
   parameter int N_PROD     = 4,
   parameter int CW         = 8,
   parameter int SW         = 4,
   parameter int MAX_CREDIT = 200
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Manage,
   input  logic              Confirm,
   input  logic [N_PROD-1:0] ProdSel,
   input  logic [CW-1:0]     PriceIn,
   input  logic [SW-1:0]     StockIn,
   input  logic              Coin50,
   input  logic              Coin100,
   input  logic              Coin500,
   input  logic              Coin1000,
   input  logic              Start,
   input  logic              Done,
   input  logic              TakeOut,
   input  logic              Return,
   output logic              Return50,
   output logic              Return100,
   output logic              Return500,
   output logic              Return1000,
   output logic              Making,
   output logic              Coffee,
   output logic [CW-1:0]     Sum,
   output logic [N_PROD-1:0] SoldOut
);
   localparam int IW = (N_PROD > 1) ? $clog2(N_PROD) : 1;
   typedef enum logic [2:0] {IDLE, PROG, CREDIT, SELECTED, MAKING, SERVE, CHANGE} state_t;
   state_t            state;
   logic [9:0]        ev_s, ev_p, ev;
   logic [N_PROD-1:0] sel_s, sel_p;
   logic [CW-1:0]     price_s;
   logic [SW-1:0]     stock_s;
   logic [CW-1:0]     price [N_PROD];
   logic [SW-1:0]     stock [N_PROD];
   logic [CW-1:0]     sum, coin_v, chg_v;
   logic [IW-1:0]     cur, idx;
   logic [3:0]        ret, coin_r, chg_r;
   logic              making, coffee, one_hot, sel_ok, fits;
   // ev bits: 0 Manage, 1 Confirm, 2..5 coins (50..1000), 6 Start, 7 Done, 8 TakeOut, 9 Return
   assign ev = ev_s & ~ev_p;
   assign one_hot = (sel_s != '0) && ((sel_s & (sel_s - N_PROD'(1))) == '0);
   always_comb begin
      idx = '0;
      for (int i = 0; i < N_PROD; i++)
         if (sel_s[i]) idx = IW'(i);
   end
   assign sel_ok = (|(sel_s & ~sel_p)) && one_hot && price[idx] != '0 && price[idx] <= sum && stock[idx] != '0;
   // Simultaneous coins: only the highest denomination is considered
   assign coin_r = ev[5] ? 4'b1000 : ev[4] ? 4'b0100 : ev[3] ? 4'b0010 : ev[2] ? 4'b0001 : 4'b0000;
   assign coin_v = ev[5] ? CW'(20) : ev[4] ? CW'(10) : ev[3] ? CW'(2) : ev[2] ? CW'(1) : '0;
   assign fits = ({1'b0, sum} + {1'b0, coin_v}) <= (CW + 1)'(MAX_CREDIT);
   assign chg_r = sum >= CW'(20) ? 4'b1000 : sum >= CW'(10) ? 4'b0100 : sum >= CW'(2) ? 4'b0010 : 4'b0001;
   assign chg_v = sum >= CW'(20) ? CW'(20) : sum >= CW'(10) ? CW'(10) : sum >= CW'(2) ? CW'(2) : CW'(1);
   always_comb
      for (int i = 0; i < N_PROD; i++) SoldOut[i] = stock[i] == '0;
   assign {Return1000, Return500, Return100, Return50} = ret;
   assign Making = making;
   assign Coffee = coffee;
   assign Sum    = sum;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         ev_s    <= '0;
         ev_p    <= '0;
         sel_s   <= '0;
         sel_p   <= '0;
         price_s <= '0;
         stock_s <= '0;
         sum     <= '0;
         cur     <= '0;
         ret     <= '0;
         making  <= 1'b0;
         coffee  <= 1'b0;
         for (int i = 0; i < N_PROD; i++) begin
            price[i] <= '0;
            stock[i] <= '0;
         end
      end else begin
         ev_s    <= {Return, TakeOut, Done, Start, Coin1000, Coin500, Coin100, Coin50, Confirm, Manage};
         ev_p    <= ev_s;
         sel_s   <= ProdSel;
         sel_p   <= sel_s;
         price_s <= PriceIn;
         stock_s <= StockIn;
         ret     <= '0;
         case (state)
            IDLE, CREDIT:
               if (ev[9] && sum != '0) state <= CHANGE;
               else if (state == IDLE && ev[0] && sum == '0) state <= PROG;
               else if (coin_v != '0) begin
                  if (fits) begin
                     sum   <= sum + coin_v;
                     state <= CREDIT;
                  end else ret <= coin_r;
               end else if (state == CREDIT && sel_ok) begin
                  cur   <= idx;
                  state <= SELECTED;
               end
            PROG:
               if (ev[0]) state <= IDLE;
               else if (ev[1] && one_hot) begin
                  price[idx] <= price_s;
                  stock[idx] <= stock_s;
               end
            SELECTED:
               if (ev[6]) begin
                  sum        <= sum - price[cur];
                  stock[cur] <= stock[cur] - SW'(1);
                  making     <= 1'b1;
                  state      <= MAKING;
               end else if (ev[9]) state <= CHANGE;
            MAKING:
               if (ev[7]) begin
                  making <= 1'b0;
                  coffee <= 1'b1;
                  state  <= SERVE;
               end
            SERVE:
               if (ev[8]) begin
                  coffee <= 1'b0;
                  state  <= (sum != '0) ? CREDIT : IDLE;
               end
            CHANGE:
               if (sum == '0) state <= IDLE;
               else begin
                  sum <= sum - chg_v;
                  ret <= chg_r;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
